// File: rtl/uart_cmd_wrapper.sv
// rtl/uart_cmd_wrapper.sv - UART command link endpoint: two RX bytes in as a 16-bit command, one response byte out.
// Optional WAIT_LO timeout under UART_CMD_WRAPPER_TIMEOUT_EN.
module uart_cmd_wrapper #(
    parameter int BAUD_DIV    = 5208,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);

    localparam logic [15:0] BIT_M1  = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);

    typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
    typedef enum logic {A_IDLE, A_WAIT_LO} asm_state_t;
    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

    rx_state_t  rx_state, rx_nxt;
    asm_state_t asm_state, asm_nxt;
    tx_state_t  tx_state, tx_nxt;

    logic        rx_ff1, rx_ff2, rx_ff3;
    logic [15:0] rx_cnt;
    logic [3:0]  rx_bit;
    logic [7:0]  rx_shreg;
    logic        rx_fall, rx_sample, rx_rdy;

    logic [7:0]  hi_byte;
    logic        timeout;

    logic [15:0] tx_cnt;
    logic [3:0]  tx_bit;
    logic [9:0]  tx_shreg;
    logic        tx_bit_end;

    // rx_ff3 is the previous synchronized value, used only for edge detection
    assign rx_fall   = rx_ff3 & ~rx_ff2;
    assign rx_sample = (rx_state == RX_RECV) && (rx_cnt == 16'd0);
    assign rx_rdy    = rx_sample && (rx_bit == 4'd9) && rx_ff2;

    always_comb begin
        rx_nxt = rx_state;
        case (rx_state)
            RX_IDLE: if (rx_fall) rx_nxt = RX_RECV;
            RX_RECV: if (rx_sample && ((rx_bit == 4'd0 && rx_ff2) || rx_bit == 4'd9))
                         rx_nxt = RX_IDLE;
            default: rx_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_ff1   <= 1'b1;
            rx_ff2   <= 1'b1;
            rx_ff3   <= 1'b1;
            rx_cnt   <= 16'd0;
            rx_bit   <= 4'd0;
            rx_shreg <= 8'd0;
        end else begin
            rx_state <= rx_nxt;
            rx_ff1   <= RX;
            rx_ff2   <= rx_ff1;
            rx_ff3   <= rx_ff2;
            if (rx_state == RX_IDLE) begin
                rx_cnt <= HALF_M1;
                rx_bit <= 4'd0;
            end else if (rx_cnt != 16'd0) begin
                rx_cnt <= rx_cnt - 16'd1;
            end else begin
                rx_cnt <= BIT_M1;
                rx_bit <= rx_bit + 4'd1;
                if (rx_bit != 4'd0 && rx_bit != 4'd9)
                    rx_shreg <= {rx_ff2, rx_shreg[7:1]};
            end
        end
    end

`ifdef UART_CMD_WRAPPER_TIMEOUT_EN
    logic [31:0] to_cnt;
    assign timeout = (to_cnt == 32'(TIMEOUT_CYC));

    always_ff @(posedge clk) begin
        if (!rst_n || asm_state == A_IDLE)
            to_cnt <= 32'd0;
        else if (!timeout)
            to_cnt <= to_cnt + 32'd1;
    end
`else
    // WAIT_LO never expires in this build
    assign timeout = (TIMEOUT_CYC < 0);
`endif

    always_comb begin
        asm_nxt = asm_state;
        case (asm_state)
            A_IDLE:    if (rx_rdy) asm_nxt = A_WAIT_LO;
            A_WAIT_LO: if (rx_rdy || timeout) asm_nxt = A_IDLE;
            default:   asm_nxt = A_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            asm_state <= A_IDLE;
            hi_byte   <= 8'd0;
            cmd       <= 16'd0;
            cmd_rdy   <= 1'b0;
        end else begin
            asm_state <= asm_nxt;
            if (asm_state == A_IDLE && rx_rdy) begin
                hi_byte <= rx_shreg;
                cmd_rdy <= 1'b0;
            end else if (asm_state == A_WAIT_LO && rx_rdy) begin
                cmd     <= {hi_byte, rx_shreg};
                cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end
        end
    end

    assign tx_bit_end = (tx_cnt == BIT_M1);
    assign TX         = (tx_state == TX_SHIFT) ? tx_shreg[0] : 1'b1;

    always_comb begin
        tx_nxt = tx_state;
        case (tx_state)
            TX_IDLE:  if (trmt) tx_nxt = TX_SHIFT;
            TX_SHIFT: if (tx_bit_end && tx_bit == 4'd9) tx_nxt = TX_IDLE;
            default:  tx_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= 16'd0;
            tx_bit   <= 4'd0;
            tx_shreg <= 10'h3FF;
            tx_done  <= 1'b0;
        end else begin
            tx_state <= tx_nxt;
            if (tx_state == TX_IDLE) begin
                tx_cnt <= 16'd0;
                tx_bit <= 4'd0;
                if (trmt) begin
                    tx_shreg <= {1'b1, resp, 1'b0};
                    tx_done  <= 1'b0;
                end
            end else if (tx_bit_end) begin
                tx_cnt   <= 16'd0;
                tx_bit   <= tx_bit + 4'd1;
                tx_shreg <= {1'b1, tx_shreg[9:1]};
                if (tx_bit == 4'd9)
                    tx_done <= 1'b1;
            end else begin
                tx_cnt <= tx_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// tb/tb_uart_cmd_wrapper.sv - directed bench with a frame-level model of uart_cmd_wrapper.
module tb_uart_cmd_wrapper;

    localparam int BD = 16;
    localparam int TO = 500;
`ifdef UART_CMD_WRAPPER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'd0;
    logic        trmt = 1'b0;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        tx_done;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    // transmit model: acceptance edge and frame of the current response
    bit         tx_valid = 1'b0;
    int         tx_start = 0;
    logic [9:0] tx_frame = 10'h3FF;

    // command model
    bit          started = 1'b0;
    bit          check_en = 1'b0;
    logic [15:0] exp_cmd = 16'd0;
    logic        exp_rdy = 1'b0;
    bit          pend = 1'b0;
    logic [7:0]  hi_m = 8'd0;
    int          hi_t = 0;

    int   last_fall = 0;
    int   rise_cyc = -1;
    int   rdy_hi_cnt = 0;
    logic rdy_q = 1'b0;
    int   e_m;
    logic exp_tx, exp_done;
    int   lat;
    logic [9:0] a5_bits;

    uart_cmd_wrapper #(.BAUD_DIV(BD), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .trmt(trmt), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n)
            tx_valid <= 1'b0;
        else if (trmt && (!tx_valid || (cyc + 1 - tx_start) >= 161)) begin
            tx_valid <= 1'b1;
            tx_start <= cyc + 1;
            tx_frame <= {1'b1, resp, 1'b0};
        end
    end

    always @(negedge clk) begin
        if (started) begin
            e_m = cyc - tx_start;
            if (tx_valid && e_m < 10 * BD) begin
                exp_tx   = tx_frame[e_m / BD];
                exp_done = 1'b0;
            end else begin
                exp_tx   = 1'b1;
                exp_done = tx_valid;
            end
            chk("tx_line", 32'(TX), 32'(exp_tx));
            chk("tx_done", 32'(tx_done), 32'(exp_done));
            if (check_en) begin
                chk("cmd", 32'(cmd), 32'(exp_cmd));
                chk("cmd_rdy", 32'(cmd_rdy), 32'(exp_rdy));
            end
            if (cmd_rdy === 1'b1 && rdy_q !== 1'b1) rise_cyc = cyc;
            if (cmd_rdy === 1'b1) rdy_hi_cnt++;
            rdy_q = cmd_rdy;
        end
    end

    // a good byte either completes a pending high byte or becomes the new high byte
    task automatic model_byte(input logic [7:0] d);
        if (pend && !(TO_EN && (cyc - hi_t) > TO)) begin
            exp_cmd = {hi_m, d};
            exp_rdy = !clr_cmd_rdy;
            pend    = 1'b0;
        end else begin
            hi_m    = d;
            hi_t    = cyc;
            pend    = 1'b1;
            exp_rdy = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit good);
        logic [9:0] f;
        f = {good, d, 1'b0};
        last_fall = cyc;
        for (int i = 0; i < 9; i++) begin
            RX = f[i];
            tick(BD);
        end
        check_en = 1'b0;
        RX = f[9];
        tick(BD);
        RX = 1'b1;
        if (good) model_byte(d);
        check_en = 1'b1;
        tick(8);
    endtask

    initial begin
        a5_bits = 10'b1101001010;
        tick(2);
        chk("reset_tx", 32'(TX), 32'd1);
        chk("reset_cmd", 32'(cmd), 32'd0);
        chk("reset_cmd_rdy", 32'(cmd_rdy), 32'd0);
        chk("reset_tx_done", 32'(tx_done), 32'd0);
        rst_n = 1'b1;
        started = 1'b1;
        check_en = 1'b1;
        tick(4);

        // 1: basic command and acknowledge
        send_byte(8'h40, 1'b1);
        rise_cyc = -1;
        send_byte(8'h22, 1'b1);
        lat = rise_cyc - last_fall;
        chk("rdy_latency_152_158", 32'(lat >= 152 && lat <= 158), 32'd1);
        chk("t1_cmd", 32'(cmd), 32'h4022);
        chk("t1_rdy", 32'(cmd_rdy), 32'd1);
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        exp_rdy = 1'b0;
        chk("t1_rdy_cleared", 32'(cmd_rdy), 32'd0);
        chk("t1_cmd_held", 32'(cmd), 32'h4022);
        tick(4);

        // 2: response A5 with an ignored mid-frame trmt
        resp = 8'hA5;
        trmt = 1'b1;
        tick(1);
        trmt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(8);
            chk("t2_tx_bit", 32'(TX), 32'(a5_bits[i]));
            if (i == 3) begin
                resp = 8'h5A;
                trmt = 1'b1;
                tick(1);
                trmt = 1'b0;
                tick(7);
            end else begin
                tick(8);
            end
        end
        chk("t2_tx_done", 32'(tx_done), 32'd1);
        tick(200);
        chk("t2_tx_idle", 32'(TX), 32'd1);

        // 3: framing error then a good command
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        chk("t3_cmd", 32'(cmd), 32'h3456);
        chk("t3_rdy", 32'(cmd_rdy), 32'd1);

        // 4: set wins over clear; new high byte drops cmd_rdy
        send_byte(8'h9A, 1'b1);
        chk("t4_hi_drops_rdy", 32'(cmd_rdy), 32'd0);
        clr_cmd_rdy = 1'b1;
        rdy_hi_cnt = 0;
        send_byte(8'hBC, 1'b1);
        clr_cmd_rdy = 1'b0;
        chk("t4_set_wins_pulse", 32'(rdy_hi_cnt), 32'd1);
        chk("t4_cmd", 32'(cmd), 32'h9ABC);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        chk("t4_rdy_set", 32'(cmd_rdy), 32'd1);
        send_byte(8'h33, 1'b1);
        chk("t4_new_hi_drop", 32'(cmd_rdy), 32'd0);
        send_byte(8'h44, 1'b1);
        chk("t4_cmd2", 32'(cmd), 32'h3344);

        // 5: long gap after high byte
        send_byte(8'hAB, 1'b1);
        tick(600);
        send_byte(8'hCD, 1'b1);
        send_byte(8'hEF, 1'b1);
`ifdef UART_CMD_WRAPPER_TIMEOUT_EN
        chk("t5_cmd", 32'(cmd), 32'hCDEF);
        chk("t5_rdy", 32'(cmd_rdy), 32'd1);
`else
        chk("t5_cmd", 32'(cmd), 32'hABCD);
        chk("t5_rdy", 32'(cmd_rdy), 32'd0);
`endif

        // 6: reset mid high byte and mid TX frame
        resp = 8'h3C;
        trmt = 1'b1;
        tick(1);
        trmt = 1'b0;
        RX = 1'b0;
        tick(40);
        check_en = 1'b0;
        rst_n = 1'b0;
        RX = 1'b1;
        tick(2);
        chk("t6_tx_reset", 32'(TX), 32'd1);
        chk("t6_rdy_reset", 32'(cmd_rdy), 32'd0);
        chk("t6_cmd_reset", 32'(cmd), 32'd0);
        rst_n = 1'b1;
        exp_cmd = 16'd0;
        exp_rdy = 1'b0;
        pend = 1'b0;
        check_en = 1'b1;
        tick(200);
        chk("t6_no_tx_done", 32'(tx_done), 32'd0);
        chk("t6_no_rdy", 32'(cmd_rdy), 32'd0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        chk("t6_cmd", 32'(cmd), 32'h0000);
        chk("t6_rdy", 32'(cmd_rdy), 32'd1);
        tick(4);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
